// File: rtl/triangle_streamer.sv
// Walks the triangle model ROM once per frame and streams each packed triangle, with a
// frame-latched camera location, over valid/ready. Optional macro: NULL_TRI_SKIP_EN.
module triangle_streamer #(
    parameter int NUM_TRIS    = 64,
    parameter int ADDRW       = 6,
    parameter int ROM_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start_in,
    input  logic [ADDRW:0]   tri_count_in,
    input  logic [27:0]      camera_loc_in,
    output logic [ADDRW-1:0] rom_addr_out,
    input  logic [63:0]      rom_data_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [63:0]      model_out,
    output logic [27:0]      camera_loc_out,
    output logic             busy_out,
    output logic             done_out
);
    localparam logic [ADDRW:0] MAX_COUNT = (ADDRW+1)'(NUM_TRIS);
    // The address register lands one cycle after entry, so data is good on wait count == LAT.
    localparam logic [2:0]     LAT       = 3'(ROM_LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

    state_t         r_state;
    logic [ADDRW:0] r_count;
    logic [ADDRW:0] r_idx;
    logic [2:0]     r_wait;
    logic [ADDRW:0] w_count_clamped;
    logic [ADDRW:0] w_next_idx;

    assign w_count_clamped = (tri_count_in > MAX_COUNT) ? MAX_COUNT : tri_count_in;
    assign w_next_idx      = r_idx + (ADDRW+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_count        <= '0;
            r_idx          <= '0;
            r_wait         <= '0;
            rom_addr_out   <= '0;
            valid_out      <= 1'b0;
            model_out      <= '0;
            camera_loc_out <= '0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start_in) begin
                        r_count        <= w_count_clamped;
                        camera_loc_out <= camera_loc_in;
                        r_idx          <= '0;
                        r_wait         <= '0;
                        busy_out       <= 1'b1;
                        if (w_count_clamped == '0) begin
                            done_out <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            rom_addr_out <= '0;
                            r_state      <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (r_wait == LAT) begin
                        r_wait <= '0;
`ifdef NULL_TRI_SKIP_EN
                        // Null word: advance without presenting; refetch restarts the wait.
                        if (rom_data_in == 64'h0) begin
                            r_idx <= w_next_idx;
                            if (w_next_idx == r_count) begin
                                done_out <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                rom_addr_out <= w_next_idx[ADDRW-1:0];
                            end
                        end else begin
                            model_out <= rom_data_in;
                            valid_out <= 1'b1;
                            r_state   <= S_PRESENT;
                        end
`else
                        model_out <= rom_data_in;
                        valid_out <= 1'b1;
                        r_state   <= S_PRESENT;
`endif
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                S_PRESENT: begin
                    if (valid_out && ready_in) begin
                        valid_out <= 1'b0;
                        r_idx     <= w_next_idx;
                        if (w_next_idx == r_count) begin
                            done_out <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            rom_addr_out <= w_next_idx[ADDRW-1:0];
                            r_wait       <= '0;
                            r_state      <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_triangle_streamer.sv
// Self-checking bench for triangle_streamer: behavioural ROM with fixed read latency and
// a list-based reference of the triangles each frame should deliver.
module tb_triangle_streamer;
    localparam int LAT = 2;
    localparam int NT  = 64;
    localparam int AW  = 6;
    localparam int LIMIT = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start_in;
    logic [AW:0]   tri_count_in;
    logic [27:0]   camera_loc_in;
    logic [AW-1:0] rom_addr_out;
    logic [63:0]   rom_data_in;
    logic          ready_in;
    logic          valid_out;
    logic [63:0]   model_out;
    logic [27:0]   camera_loc_out;
    logic          busy_out;
    logic          done_out;

    triangle_streamer #(.NUM_TRIS(NT), .ADDRW(AW), .ROM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .frame_start_in(frame_start_in), .tri_count_in(tri_count_in),
        .camera_loc_in(camera_loc_in), .rom_addr_out(rom_addr_out), .rom_data_in(rom_data_in),
        .ready_in(ready_in), .valid_out(valid_out), .model_out(model_out),
        .camera_loc_out(camera_loc_out), .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk = ~clk;

    // ROM: data visible LAT cycles after the address is presented
    logic [63:0]   rom [NT];
    logic [AW-1:0] ap [1:4];
    always @(posedge clk) begin
        ap[1] <= rom_addr_out;
        for (int k = 2; k <= 4; k++) ap[k] <= ap[k-1];
    end
    assign rom_data_in = rom[ap[LAT]];

    int n_cmp = 0;
    int n_err = 0;
    int rel;
    int n_valid, n_done, n_stall_bad, stall_cnt;
    logic        prev_v, prev_r;
    logic [63:0] prev_m;
    logic [27:0] prev_c;
    logic [63:0] xm_q[$];
    logic [27:0] xc_q[$];
    int          xt_q[$];
    logic [63:0] exp_q[$];

    // Reference: the first min(count, NUM_TRIS) ROM words, in order, minus nulls when skipping
    function automatic void build_exp(input int cnt);
        int n;
        exp_q.delete();
        n = (cnt > NT) ? NT : cnt;
        for (int i = 0; i < n; i++) begin
`ifdef NULL_TRI_SKIP_EN
            if (rom[i] == 64'h0) continue;
`endif
            exp_q.push_back(rom[i]);
        end
    endfunction

    task automatic fill_rom(input int zero_pct);
        for (int i = 0; i < NT; i++) begin
            rom[i] = {$urandom, $urandom};
            if (rom[i] == 64'h0) rom[i] = 64'h1;
            if ($urandom_range(0, 99) < zero_pct) rom[i] = 64'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_start_in = 1'b0; tri_count_in = '0; camera_loc_in = '0; ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic sample();
        if (valid_out) n_valid++;
        if (valid_out && ready_in) begin
            xm_q.push_back(model_out); xc_q.push_back(camera_loc_out); xt_q.push_back(rel);
        end
        if (done_out) n_done++;
        if (prev_v && !prev_r && (!valid_out || model_out !== prev_m || camera_loc_out !== prev_c))
            n_stall_bad++;
        prev_v = valid_out; prev_r = ready_in; prev_m = model_out; prev_c = camera_loc_out;
    endtask

    function automatic logic pick_ready(input int mode);
        if (mode == 1) return 1'($urandom_range(0, 1));
        if (mode == 2) begin
            if (valid_out && stall_cnt < 5) begin stall_cnt++; return 1'b0; end
        end
        return 1'b1;
    endfunction

    // mode: 0 ready tied high, 1 random ready, 2 five-cycle stall on first triangle,
    // 3 mid-frame camera change plus a frame_start while busy
    task automatic run_frame(input int cnt, input logic [27:0] cam, input int mode,
                             output int done_rel, output int tout);
        xm_q.delete(); xc_q.delete(); xt_q.delete();
        n_valid = 0; n_done = 0; n_stall_bad = 0; stall_cnt = 0; prev_v = 1'b0; prev_r = 1'b0;
        done_rel = -1; tout = 0;
        @(posedge clk); #1;
        rel = 0; tri_count_in = 7'(cnt); camera_loc_in = cam; frame_start_in = 1'b1;
        ready_in = pick_ready(mode);
        @(negedge clk); sample();
        forever begin
            @(posedge clk); #1;
            rel++;
            frame_start_in = 1'b0;
            if (mode == 3 && rel == 6) begin
                frame_start_in = 1'b1; camera_loc_in = 28'h1234567; tri_count_in = 7'd9;
            end
            ready_in = pick_ready(mode);
            @(negedge clk); sample();
            if (done_out) begin done_rel = rel; break; end
            if (rel > LIMIT) begin tout = 1; break; end
        end
        frame_start_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid_out); end
        n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_out); end
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_out); end
        n_cmp++; if (rom_addr_out !== '0) begin n_err++; $display("FAIL reset_addr got %h want 0", rom_addr_out); end
        n_cmp++; if (model_out !== 64'h0) begin n_err++; $display("FAIL reset_model got %h want 0", model_out); end
        n_cmp++; if (camera_loc_out !== 28'h0) begin n_err++; $display("FAIL reset_cam got %h want 0", camera_loc_out); end
    endtask

    task automatic test_basic();
        int dr, to;
        fill_rom(0);
        run_frame(3, 28'h0123456, 0, dr, to);
        build_exp(3);
        n_cmp++; if (to != 0) begin n_err++; $display("FAIL basic_timeout got %0d want 0", to); end
        n_cmp++; if (xm_q.size() != 3) begin n_err++; $display("FAIL basic_count got %0d want 3", xm_q.size()); end
        for (int i = 0; i < 3 && i < xm_q.size(); i++) begin
            n_cmp++; if (xm_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_model[%0d] got %h want %h", i, xm_q[i], exp_q[i]); end
            n_cmp++; if (xt_q[i] != (2 + LAT) * (i + 1)) begin n_err++; $display("FAIL basic_valid_cycle[%0d] got %0d want %0d", i, xt_q[i], (2 + LAT) * (i + 1)); end
        end
        n_cmp++; if (dr != 3 * (2 + LAT) + 1) begin n_err++; $display("FAIL basic_done_cycle got %0d want %0d", dr, 3 * (2 + LAT) + 1); end
        @(posedge clk); #1;
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %b want 0", busy_out); end
        n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", n_done); end
    endtask

    task automatic test_stall();
        int dr, to;
        fill_rom(0);
        run_frame(2, 28'h7654321, 2, dr, to);
        build_exp(2);
        n_cmp++; if (xm_q.size() != 2 || to != 0) begin n_err++; $display("FAIL stall_count got %0d want 2 (timeout %0d)", xm_q.size(), to); end
        for (int i = 0; i < 2 && i < xm_q.size(); i++) begin
            n_cmp++; if (xm_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_model[%0d] got %h want %h", i, xm_q[i], exp_q[i]); end
        end
        n_cmp++; if (n_stall_bad != 0) begin n_err++; $display("FAIL stall_hold got %0d unstable cycles want 0", n_stall_bad); end
        n_cmp++; if (stall_cnt != 5) begin n_err++; $display("FAIL stall_cycles got %0d want 5", stall_cnt); end
        n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL stall_done_pulses got %0d want 1", n_done); end
    endtask

    task automatic test_camera();
        int dr, to;
        fill_rom(0);
        run_frame(3, 28'hABCDE12, 3, dr, to);
        n_cmp++; if (xc_q.size() != 3 || to != 0) begin n_err++; $display("FAIL cam_count got %0d want 3 (timeout %0d)", xc_q.size(), to); end
        for (int i = 0; i < xc_q.size(); i++) begin
            n_cmp++; if (xc_q[i] !== 28'hABCDE12) begin n_err++; $display("FAIL cam_loc[%0d] got %h want abcde12", i, xc_q[i]); end
        end
        // frame_start during the DONE cycle must be dropped
        frame_start_in = 1'b1; tri_count_in = 7'd4;
        @(posedge clk); #1 frame_start_in = 1'b0;
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL cam_start_in_done got busy %b want 0", busy_out); end
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (busy_out !== 1'b0 || valid_out !== 1'b0) begin n_err++; $display("FAIL cam_idle_after got busy %b valid %b want 0 0", busy_out, valid_out); end
    endtask

    task automatic test_bounds();
        int dr, to;
        fill_rom(0);
        run_frame(0, 28'h1111111, 0, dr, to);
        n_cmp++; if (dr != 1) begin n_err++; $display("FAIL zero_done_cycle got %0d want 1", dr); end
        n_cmp++; if (n_valid != 0) begin n_err++; $display("FAIL zero_valid got %0d cycles want 0", n_valid); end
        @(posedge clk); #1;
        run_frame(100, 28'h2222222, 0, dr, to);
        build_exp(100);
        n_cmp++; if (xm_q.size() != exp_q.size() || to != 0) begin n_err++; $display("FAIL clamp_count got %0d want %0d", xm_q.size(), exp_q.size()); end
        n_cmp++; if (xm_q.size() != NT) begin n_err++; $display("FAIL clamp_total got %0d want %0d", xm_q.size(), NT); end
        for (int i = 0; i < xm_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (xm_q[i] !== exp_q[i]) begin n_err++; $display("FAIL clamp_model[%0d] got %h want %h", i, xm_q[i], exp_q[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int dr, to, waited, dones;
        fill_rom(0);
        @(posedge clk); #1;
        tri_count_in = 7'd5; camera_loc_in = 28'h3333333; frame_start_in = 1'b1; ready_in = 1'b0;
        waited = 0;
        do begin
            @(posedge clk); #1 frame_start_in = 1'b0; waited++;
        end while (!valid_out && waited < 50);
        n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL rstmid_reach_valid got %b want 1", valid_out); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (valid_out !== 1'b0 || busy_out !== 1'b0) begin n_err++; $display("FAIL rstmid_abort got valid %b busy %b want 0 0", valid_out, busy_out); end
        rst = 1'b0; ready_in = 1'b1; dones = 0;
        repeat (10) begin
            @(negedge clk); if (done_out) dones++;
        end
        n_cmp++; if (dones != 0) begin n_err++; $display("FAIL rstmid_no_done got %0d want 0", dones); end
        run_frame(2, 28'h4444444, 0, dr, to);
        n_cmp++; if (xm_q.size() != 2 || to != 0) begin n_err++; $display("FAIL rstmid_restart_count got %0d want 2", xm_q.size()); end
        n_cmp++; if (xm_q.size() > 0 && xm_q[0] !== rom[0]) begin n_err++; $display("FAIL rstmid_restart_addr0 got %h want %h", xm_q[0], rom[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_null();
        int dr, to;
        fill_rom(0);
        rom[1] = 64'h0;
        run_frame(3, 28'h5555555, 0, dr, to);
        build_exp(3);
`ifdef NULL_TRI_SKIP_EN
        n_cmp++; if (xm_q.size() != 2) begin n_err++; $display("FAIL null_count got %0d want 2", xm_q.size()); end
`else
        n_cmp++; if (xm_q.size() != 3) begin n_err++; $display("FAIL null_count got %0d want 3", xm_q.size()); end
`endif
        for (int i = 0; i < xm_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (xm_q[i] !== exp_q[i]) begin n_err++; $display("FAIL null_model[%0d] got %h want %h", i, xm_q[i], exp_q[i]); end
        end
        n_cmp++; if (n_done != 1 || to != 0) begin n_err++; $display("FAIL null_done got %0d want 1", n_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int dr, to, cnt;
        logic [27:0] cam;
        for (int f = 0; f < 8; f++) begin
            fill_rom(12);
            cnt = $urandom_range(0, 80);
            cam = 28'($urandom);
            run_frame(cnt, cam, 1, dr, to);
            build_exp(cnt);
            n_cmp++; if (xm_q.size() != exp_q.size() || to != 0) begin n_err++; $display("FAIL rand%0d_count got %0d want %0d (cnt %0d)", f, xm_q.size(), exp_q.size(), cnt); end
            for (int i = 0; i < xm_q.size() && i < exp_q.size(); i++) begin
                n_cmp++; if (xm_q[i] !== exp_q[i] || xc_q[i] !== cam) begin n_err++; $display("FAIL rand%0d_xfer[%0d] got %h/%h want %h/%h", f, i, xm_q[i], xc_q[i], exp_q[i], cam); end
            end
            n_cmp++; if (n_stall_bad != 0 || n_done != 1) begin n_err++; $display("FAIL rand%0d_protocol got unstable %0d done %0d want 0 1", f, n_stall_bad, n_done); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_camera();
        test_bounds();
        test_reset_mid();
        test_null();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
